// File: rtl/ps2_key_events_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_events_if
// Description : Byte-handshake (ps2_keyboard receiver side) and event-stream
//               (consumer side) signals of the PS/2 key event front end.
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_key_events_if;
    logic [7:0] ps2_data;
    logic       ps2_ready;
    logic       ps2_nextdata_n;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic [7:0] evt_ascii;

    // Event front end: consumes bytes, produces events
    modport slave (
        input  ps2_data, ps2_ready, evt_ready,
        output ps2_nextdata_n, evt_valid, evt_code, evt_ext, evt_break, evt_ascii
    );

    // Environment: supplies bytes, consumes events
    modport master (
        output ps2_data, ps2_ready, evt_ready,
        input  ps2_nextdata_n, evt_valid, evt_code, evt_ext, evt_break, evt_ascii
    );
endinterface
`default_nettype wire

// File: rtl/ps2_key_events.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_events
// Description : Set-2 PS/2 scan-code parser producing make/break key events
//               with shift/caps tracking, typematic repeat suppression, a
//               press counter and an event FIFO with valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_events #(
    parameter int FIFO_DEPTH      = 8,
    parameter int CNT_W           = 8,
    parameter int SUPPRESS_REPEAT = 1
) (
    input  logic             clk,
    input  logic             rest,
    ps2_key_events_if.slave  bus,
    output logic [CNT_W-1:0] press_cnt,
    output logic             shift,
    output logic             caps,
    output logic             key_held,
    output logic             fifo_overflow
);

    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam bit c_suppress = (SUPPRESS_REPEAT != 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_nd_n;
    logic             w_cap;
    logic             w_err;
    logic             w_evt;
    logic             w_evt_ext;
    logic             w_evt_brk;

    logic             r_held_v;
    logic             r_held_ext;
    logic [7:0]       r_held_code;
    logic             r_lshift;
    logic             r_rshift;
    logic             r_caps;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    logic             w_match;
    logic             w_make_acc;
    logic             w_push;
    logic             w_letter;
    logic [4:0]       w_idx;
    logic [7:0]       w_ascii_raw;
    logic [7:0]       w_ascii;

    logic [17:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic [PTR_W:0]   w_count;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push_ok;
    logic [17:0]      w_head;

    // A byte is taken only while the consume strobe is idle, so each capture
    // is followed by exactly one low cycle of ps2_nextdata_n.
    assign w_cap = bus.ps2_ready & r_nd_n;
    assign w_err = (bus.ps2_data == 8'h00) | (bus.ps2_data == 8'hFF);

    // Handshake strobe and parser state register
    always_ff @(posedge clk) begin
        if (rest) begin
            r_nd_n  <= 1'b1;
            r_state <= S_IDLE;
        end else begin
            r_nd_n  <= ~w_cap;
            r_state <= w_state_nxt;
        end
    end

    // Parser next state; an event completes on the capture edge of its last byte
    always_comb begin
        w_state_nxt = r_state;
        w_evt       = 1'b0;
        w_evt_ext   = 1'b0;
        w_evt_brk   = 1'b0;
        if (w_cap) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.ps2_data == 8'hE0)      w_state_nxt = S_EXT;
                    else if (bus.ps2_data == 8'hF0) w_state_nxt = S_BRK;
                    else if (!w_err)                w_evt       = 1'b1;
                end
                S_EXT: begin
                    if (bus.ps2_data == 8'hF0) begin
                        w_state_nxt = S_EXT_BRK;
                    end else if (bus.ps2_data != 8'hE0) begin
                        w_state_nxt = S_IDLE;
                        w_evt       = ~w_err;
                        w_evt_ext   = 1'b1;
                    end
                end
                default: begin
                    // Both break states: any prefix or error byte aborts the sequence
                    w_state_nxt = S_IDLE;
                    w_evt_brk   = 1'b1;
                    w_evt_ext   = (r_state == S_EXT_BRK);
                    w_evt       = ~(w_err | (bus.ps2_data == 8'hE0) | (bus.ps2_data == 8'hF0));
                end
            endcase
        end
    end

    assign w_match    = r_held_v & (r_held_ext == w_evt_ext) & (r_held_code == bus.ps2_data);
    assign w_make_acc = w_evt & ~w_evt_brk & ~(c_suppress & w_match);
    assign w_push     = w_make_acc | (w_evt & w_evt_brk);

    // Scan code to ASCII using the modifier state from before this event
    always_comb begin
        w_letter    = 1'b0;
        w_idx       = 5'd0;
        w_ascii_raw = 8'h00;
        case (bus.ps2_data)
            8'h1C: begin w_letter = 1'b1; w_idx = 5'd0;  end
            8'h32: begin w_letter = 1'b1; w_idx = 5'd1;  end
            8'h21: begin w_letter = 1'b1; w_idx = 5'd2;  end
            8'h23: begin w_letter = 1'b1; w_idx = 5'd3;  end
            8'h24: begin w_letter = 1'b1; w_idx = 5'd4;  end
            8'h2B: begin w_letter = 1'b1; w_idx = 5'd5;  end
            8'h34: begin w_letter = 1'b1; w_idx = 5'd6;  end
            8'h33: begin w_letter = 1'b1; w_idx = 5'd7;  end
            8'h43: begin w_letter = 1'b1; w_idx = 5'd8;  end
            8'h3B: begin w_letter = 1'b1; w_idx = 5'd9;  end
            8'h42: begin w_letter = 1'b1; w_idx = 5'd10; end
            8'h4B: begin w_letter = 1'b1; w_idx = 5'd11; end
            8'h3A: begin w_letter = 1'b1; w_idx = 5'd12; end
            8'h31: begin w_letter = 1'b1; w_idx = 5'd13; end
            8'h44: begin w_letter = 1'b1; w_idx = 5'd14; end
            8'h4D: begin w_letter = 1'b1; w_idx = 5'd15; end
            8'h15: begin w_letter = 1'b1; w_idx = 5'd16; end
            8'h2D: begin w_letter = 1'b1; w_idx = 5'd17; end
            8'h1B: begin w_letter = 1'b1; w_idx = 5'd18; end
            8'h2C: begin w_letter = 1'b1; w_idx = 5'd19; end
            8'h3C: begin w_letter = 1'b1; w_idx = 5'd20; end
            8'h2A: begin w_letter = 1'b1; w_idx = 5'd21; end
            8'h1D: begin w_letter = 1'b1; w_idx = 5'd22; end
            8'h22: begin w_letter = 1'b1; w_idx = 5'd23; end
            8'h35: begin w_letter = 1'b1; w_idx = 5'd24; end
            8'h1A: begin w_letter = 1'b1; w_idx = 5'd25; end
            8'h45: w_ascii_raw = 8'h30;
            8'h16: w_ascii_raw = 8'h31;
            8'h1E: w_ascii_raw = 8'h32;
            8'h26: w_ascii_raw = 8'h33;
            8'h25: w_ascii_raw = 8'h34;
            8'h2E: w_ascii_raw = 8'h35;
            8'h36: w_ascii_raw = 8'h36;
            8'h3D: w_ascii_raw = 8'h37;
            8'h3E: w_ascii_raw = 8'h38;
            8'h46: w_ascii_raw = 8'h39;
            8'h29: w_ascii_raw = 8'h20;
            8'h5A: w_ascii_raw = 8'h0D;
            8'h66: w_ascii_raw = 8'h08;
            default: w_ascii_raw = 8'h00;
        endcase
        if (w_letter) begin
            w_ascii_raw = (((r_lshift | r_rshift) ^ r_caps) ? 8'h41 : 8'h61) + {3'b000, w_idx};
        end
        w_ascii = (w_evt_brk | w_evt_ext) ? 8'h00 : w_ascii_raw;
    end

    // Held key, modifiers and press counter follow every completed event,
    // independent of whether the FIFO had room for it
    always_ff @(posedge clk) begin
        if (rest) begin
            r_held_v    <= 1'b0;
            r_held_ext  <= 1'b0;
            r_held_code <= 8'h00;
            r_lshift    <= 1'b0;
            r_rshift    <= 1'b0;
            r_caps      <= 1'b0;
            r_cnt       <= '0;
        end else if (w_make_acc) begin
            r_held_v    <= 1'b1;
            r_held_ext  <= w_evt_ext;
            r_held_code <= bus.ps2_data;
            r_cnt       <= r_cnt + CNT_W'(1);
            if (!w_evt_ext && bus.ps2_data == 8'h12) r_lshift <= 1'b1;
            if (!w_evt_ext && bus.ps2_data == 8'h59) r_rshift <= 1'b1;
            if (!w_evt_ext && bus.ps2_data == 8'h58) r_caps   <= ~r_caps;
        end else if (w_evt && w_evt_brk) begin
            if (w_match) r_held_v <= 1'b0;
            if (!w_evt_ext && bus.ps2_data == 8'h12) r_lshift <= 1'b0;
            if (!w_evt_ext && bus.ps2_data == 8'h59) r_rshift <= 1'b0;
        end
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (w_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_pop     = ~w_empty & bus.evt_ready;
    assign w_push_ok = w_push & (~w_full | w_pop);

    // FIFO pointers and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rest) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok)          r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_pop)              r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
            if (w_push & ~w_push_ok) r_ovf   <= 1'b1;
        end
    end

    // FIFO storage: {code, ext, break, ascii}
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= {bus.ps2_data, w_evt_ext, w_evt_brk, w_ascii};
        end
    end

    assign w_head             = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign bus.ps2_nextdata_n = r_nd_n;
    assign bus.evt_valid      = ~w_empty;
    assign bus.evt_code       = w_empty ? 8'h00 : w_head[17:10];
    assign bus.evt_ext        = ~w_empty & w_head[9];
    assign bus.evt_break      = ~w_empty & w_head[8];
    assign bus.evt_ascii      = w_empty ? 8'h00 : w_head[7:0];

    assign press_cnt     = r_cnt;
    assign shift         = r_lshift | r_rshift;
    assign caps          = r_caps;
    assign key_held      = r_held_v;
    assign fifo_overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_events.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_events
// Description : Bench for ps2_key_events; two instances (repeat suppression
//               on/off) share one byte stream and consumer, each compared
//               every cycle against an event-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_events;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       tb_rest = 1'b1;
    logic       tb_rdy = 1'b0;
    logic [7:0] tb_data = 8'h00;
    logic       tb_evr = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    ps2_key_events_if if0();
    ps2_key_events_if if1();

    logic [7:0] cnt0, cnt1;
    logic       sh0, sh1, cp0, cp1, kh0, kh1, ov0, ov1;

    assign if0.ps2_data  = tb_data;
    assign if0.ps2_ready = tb_rdy;
    assign if0.evt_ready = tb_evr;
    assign if1.ps2_data  = tb_data;
    assign if1.ps2_ready = tb_rdy;
    assign if1.evt_ready = tb_evr;

    ps2_key_events #(.FIFO_DEPTH(DEPTH), .CNT_W(8), .SUPPRESS_REPEAT(1)) u_dut0 (
        .clk(clk), .rest(tb_rest), .bus(if0), .press_cnt(cnt0), .shift(sh0),
        .caps(cp0), .key_held(kh0), .fifo_overflow(ov0)
    );
    ps2_key_events #(.FIFO_DEPTH(DEPTH), .CNT_W(8), .SUPPRESS_REPEAT(0)) u_dut1 (
        .clk(clk), .rest(tb_rest), .bus(if1), .press_cnt(cnt1), .shift(sh1),
        .caps(cp1), .key_held(kh1), .fifo_overflow(ov1)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (event level) ----------------
    logic [7:0] c_let [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
                               8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
                               8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    logic [7:0] c_dig [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    logic [7:0] c_pool [24] = '{8'h1C,8'h32,8'h21,8'h1B,8'h45,8'h16,8'h29,8'h5A,8'h66,8'h12,
                                8'h59,8'h58,8'hE0,8'hF0,8'hF0,8'hE0,8'h00,8'hFF,8'h75,8'h6B,
                                8'h1C,8'h1C,8'hF0,8'h33};

    logic       m_nd;
    logic       m_pext [2], m_pbrk [2], m_hv [2], m_hext [2];
    logic       m_l [2], m_r [2], m_caps [2], m_ovf [2];
    logic [7:0] m_hcode [2], m_cnt [2];
    logic [17:0] q0 [$];
    logic [17:0] q1 [$];

    function automatic logic [7:0] ascii_of(logic [7:0] code, logic upper);
        for (int k = 0; k < 26; k++)
            if (code == c_let[k]) return (upper ? 8'h41 : 8'h61) + 8'(k);
        for (int k = 0; k < 10; k++)
            if (code == c_dig[k]) return 8'h30 + 8'(k);
        if (code == 8'h29) return 8'h20;
        if (code == 8'h5A) return 8'h0D;
        if (code == 8'h66) return 8'h08;
        return 8'h00;
    endfunction

    function automatic int qsize(int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    task automatic mpush(int i, logic [17:0] e);
        if (qsize(i) >= DEPTH) m_ovf[i] = 1'b1;
        else if (i == 0)       q0.push_back(e);
        else                   q1.push_back(e);
    endtask

    task automatic model_reset();
        m_nd = 1'b1;
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            m_pext[i] = 0; m_pbrk[i] = 0; m_hv[i] = 0; m_hext[i] = 0; m_hcode[i] = 0;
            m_l[i] = 0; m_r[i] = 0; m_caps[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_event(int i, logic ext, logic brk, logic [7:0] code);
        logic [7:0] asc;
        if (!brk) begin
            if (i == 0 && m_hv[i] && m_hext[i] == ext && m_hcode[i] == code) return;
            asc = ext ? 8'h00 : ascii_of(code, (m_l[i] | m_r[i]) ^ m_caps[i]);
            mpush(i, {code, ext, 1'b0, asc});
            m_cnt[i] = m_cnt[i] + 8'd1;
            m_hv[i] = 1; m_hext[i] = ext; m_hcode[i] = code;
            if (!ext && code == 8'h12) m_l[i] = 1;
            if (!ext && code == 8'h59) m_r[i] = 1;
            if (!ext && code == 8'h58) m_caps[i] = ~m_caps[i];
        end else begin
            if (m_hv[i] && m_hext[i] == ext && m_hcode[i] == code) m_hv[i] = 0;
            mpush(i, {code, ext, 1'b1, 8'h00});
            if (!ext && code == 8'h12) m_l[i] = 0;
            if (!ext && code == 8'h59) m_r[i] = 0;
        end
    endtask

    // Prefix bookkeeping as two pending flags: E0 marks extended, F0 marks break,
    // any prefix/error while a break is pending aborts the sequence.
    task automatic model_byte(int i, logic [7:0] b);
        if (b == 8'h00 || b == 8'hFF) begin
            m_pext[i] = 0; m_pbrk[i] = 0;
        end else if (b == 8'hE0 || b == 8'hF0) begin
            if (m_pbrk[i]) begin m_pext[i] = 0; m_pbrk[i] = 0; end
            else if (b == 8'hE0) m_pext[i] = 1;
            else                 m_pbrk[i] = 1;
        end else begin
            model_event(i, m_pext[i], m_pbrk[i], b);
            m_pext[i] = 0; m_pbrk[i] = 0;
        end
    endtask

    task automatic model_edge();
        logic cap;
        cap = tb_rdy && m_nd;
        if (q0.size() > 0 && tb_evr) void'(q0.pop_front());
        if (q1.size() > 0 && tb_evr) void'(q1.pop_front());
        m_nd = !cap;
        if (cap) begin
            model_byte(0, tb_data);
            model_byte(1, tb_data);
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_inst(int i, logic nd, logic v, logic [7:0] code, logic ext,
                              logic brk, logic [7:0] asc, logic [7:0] cnt, logic sh,
                              logic cp, logic kh, logic ov);
        logic [17:0] h;
        h = 18'h0;
        if (qsize(i) != 0) h = (i == 0) ? q0[0] : q1[0];
        chk($sformatf("u%0d.nextdata_n", i), 32'(nd), 32'(m_nd));
        chk($sformatf("u%0d.evt_valid", i), 32'(v), 32'(qsize(i) != 0));
        chk($sformatf("u%0d.evt_code", i), 32'(code), 32'(h[17:10]));
        chk($sformatf("u%0d.evt_ext", i), 32'(ext), 32'(h[9]));
        chk($sformatf("u%0d.evt_break", i), 32'(brk), 32'(h[8]));
        chk($sformatf("u%0d.evt_ascii", i), 32'(asc), 32'(h[7:0]));
        chk($sformatf("u%0d.press_cnt", i), 32'(cnt), 32'(m_cnt[i]));
        chk($sformatf("u%0d.shift", i), 32'(sh), 32'(m_l[i] | m_r[i]));
        chk($sformatf("u%0d.caps", i), 32'(cp), 32'(m_caps[i]));
        chk($sformatf("u%0d.key_held", i), 32'(kh), 32'(m_hv[i]));
        chk($sformatf("u%0d.fifo_overflow", i), 32'(ov), 32'(m_ovf[i]));
    endtask

    task automatic check_all();
        check_inst(0, if0.ps2_nextdata_n, if0.evt_valid, if0.evt_code, if0.evt_ext,
                   if0.evt_break, if0.evt_ascii, cnt0, sh0, cp0, kh0, ov0);
        check_inst(1, if1.ps2_nextdata_n, if1.evt_valid, if1.evt_code, if1.evt_ext,
                   if1.evt_break, if1.evt_ascii, cnt1, sh1, cp1, kh1, ov1);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cyc(logic rdy, logic [7:0] b, logic evr);
        tb_rdy = rdy; tb_data = b; tb_evr = evr;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic reset_cyc();
        tb_rest = 1'b1; tb_rdy = 1'b0; tb_evr = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        tb_rest = 1'b0;
        check_all();
    endtask

    task automatic send(logic [7:0] b, logic evr);
        cyc(1'b1, b, evr);
        cyc(1'b0, 8'h00, evr);
    endtask

    task automatic drain();
        repeat (DEPTH + 2) cyc(1'b0, 8'h00, 1'b1);
    endtask

    function automatic logic [7:0] rnd_byte();
        if ($urandom_range(7) == 0) return 8'($urandom);
        return c_pool[$urandom_range(23)];
    endfunction

    initial begin
        // Basic make/break of 'a'
        reset_cyc();
        send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0);
        chk("plan1.head_ascii", 32'(if0.evt_ascii), 32'h61);
        chk("plan1.press_cnt", 32'(cnt0), 32'd1);
        chk("plan1.key_held", 32'(kh0), 32'd0);
        drain();

        // Shift and caps lock
        send(8'h12, 1); send(8'h1C, 1); send(8'hF0, 1); send(8'h1C, 1);
        send(8'hF0, 1); send(8'h12, 1);
        send(8'h58, 1); send(8'hF0, 1); send(8'h58, 1);
        chk("plan2.caps_on", 32'(cp0), 32'd1);
        send(8'h1C, 0);
        chk("plan2.caps_upper", 32'(if0.evt_ascii), 32'h41);
        drain();
        send(8'h58, 1); send(8'h1C, 1); send(8'hF0, 1); send(8'h1C, 1);
        drain();

        // Extended key make/break
        send(8'hE0, 1); send(8'h75, 1); send(8'hE0, 1); send(8'hF0, 1); send(8'h75, 1);
        drain();

        // Typematic repeat
        reset_cyc();
        repeat (5) send(8'h1C, 0);
        send(8'hF0, 0); send(8'h1C, 0);
        chk("plan4.cnt_suppress", 32'(cnt0), 32'd1);
        chk("plan4.cnt_nosuppress", 32'(cnt1), 32'd5);
        drain();

        // Overflow, then full-with-pop acceptance
        reset_cyc();
        for (int k = 0; k < 9; k++) send(c_let[k], 0);
        chk("plan5.overflow", 32'(ov0), 32'd1);
        chk("plan5.press_cnt", 32'(cnt0), 32'd9);
        cyc(1'b1, c_let[9], 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        drain();

        // Reset mid-sequence, then press counter wrap
        send(8'hE0, 0); send(8'hF0, 0);
        reset_cyc();
        send(8'h1C, 0);
        chk("plan6.code_after_reset", 32'(if0.evt_code), 32'h1C);
        chk("plan6.brk_after_reset", 32'(if0.evt_break), 32'd0);
        reset_cyc();
        for (int k = 0; k < 256; k++) begin
            send(8'h1C, 1); send(8'hF0, 1); send(8'h1C, 1);
        end
        chk("plan6.cnt_wrap", 32'(cnt0), 32'd0);
        drain();

        // Randomized traffic: ready held across cycles, bursty consumer, rare resets
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(399) == 0) reset_cyc();
            else cyc(1'($urandom_range(2) != 0), rnd_byte(),
                     ((k / 250) % 2 == 0) ? 1'($urandom_range(3) == 0) : 1'($urandom_range(3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
